// File: rtl/feistel_round_ctrl_if.sv
// Request, result and Feistel-datapath signals of feistel_round_ctrl.
// in_decrypt exists only when FEISTEL_CTRL_DECRYPT_EN is defined.
interface feistel_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [47:0] in_seed;
`ifdef FEISTEL_CTRL_DECRYPT_EN
    logic        in_decrypt;
`endif
    logic [31:0] f_left;
    logic [31:0] f_right;
    logic [47:0] f_key;
    logic [31:0] f_left_out;
    logic [31:0] f_right_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;
    logic        busy;

    // master: requester, consumer and the external Feistel function
    modport master (
        output in_valid, in_block, in_seed,
`ifdef FEISTEL_CTRL_DECRYPT_EN
        output in_decrypt,
`endif
        input  in_ready,
        input  f_left, f_right, f_key,
        output f_left_out, f_right_out,
        input  out_valid, out_block, busy,
        output out_ready
    );

    // slave: the round controller
    modport slave (
        input  in_valid, in_block, in_seed,
`ifdef FEISTEL_CTRL_DECRYPT_EN
        input  in_decrypt,
`endif
        output in_ready,
        output f_left, f_right, f_key,
        input  f_left_out, f_right_out,
        output out_valid, out_block, busy,
        input  out_ready
    );
endinterface

// File: rtl/feistel_round_ctrl.sv
// Sequences NUM_ROUNDS passes of an external Feistel function with an LFSR key schedule.
// Optional macro FEISTEL_CTRL_DECRYPT_EN adds in_decrypt and the KEYFWD key pre-advance state.
module feistel_round_ctrl #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    feistel_round_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef FEISTEL_CTRL_DECRYPT_EN
    localparam logic [1:0] S_KEYFWD = 2'd1;
`endif
    localparam logic [1:0] S_ROUND  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [4:0]  LAST_RND = 5'(NUM_ROUNDS - 1);
    localparam logic [47:0] SEED_FIX = 48'h0000_0000_0001;

`ifdef FEISTEL_CTRL_DECRYPT_EN
    localparam logic [4:0]  LAST_FWD = 5'(NUM_ROUNDS - 2);
    localparam bit          HAS_FWD  = (NUM_ROUNDS > 1);
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [47:0] key_q, key_d;
    logic [4:0]  rnd_q, rnd_d;
`ifdef FEISTEL_CTRL_DECRYPT_EN
    logic        dec_q, dec_d;
`endif

    logic        in_ready;
    logic        out_valid;
    logic        in_round;
    logic        accept;
    logic [47:0] seed_eff;

    function automatic logic [47:0] lfsr_fwd(input logic [47:0] k);
        return {k[46:0], k[47] ^ k[46] ^ k[20] ^ k[19]};
    endfunction

`ifdef FEISTEL_CTRL_DECRYPT_EN
    // Exact inverse of lfsr_fwd: recovers the bit shifted out of the top.
    function automatic logic [47:0] lfsr_rev(input logic [47:0] k);
        return {k[0] ^ k[47] ^ k[21] ^ k[20], k[47:1]};
    endfunction
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign in_round  = (state_q == S_ROUND);
    assign accept    = bus.in_valid & in_ready;
    // An all-zero LFSR would never leave zero, so substitute a fixed nonzero seed.
    assign seed_eff  = (bus.in_seed == '0) ? SEED_FIX : bus.in_seed;

    always_comb begin
        // NOTE: every next-state variable gets a hold default first, so no path infers a latch.
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
`ifdef FEISTEL_CTRL_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    l_d     = bus.in_block[63:32];
                    r_d     = bus.in_block[31:0];
                    key_d   = seed_eff;
                    rnd_d   = '0;
                    state_d = S_ROUND;
`ifdef FEISTEL_CTRL_DECRYPT_EN
                    dec_d   = bus.in_decrypt;
                    if (bus.in_decrypt && HAS_FWD) begin
                        state_d = S_KEYFWD;
                    end
`endif
                end
            end
`ifdef FEISTEL_CTRL_DECRYPT_EN
            // Walk the key to the last round's value so decryption can step backwards.
            S_KEYFWD: begin
                key_d = lfsr_fwd(key_q);
                if (rnd_q == LAST_FWD) begin
                    rnd_d   = '0;
                    state_d = S_ROUND;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
`endif
            S_ROUND: begin
                l_d   = bus.f_left_out;
                r_d   = bus.f_right_out;
                rnd_d = rnd_q + 5'd1;
`ifdef FEISTEL_CTRL_DECRYPT_EN
                key_d = dec_q ? lfsr_rev(key_q) : lfsr_fwd(key_q);
`else
                key_d = lfsr_fwd(key_q);
`endif
                if (rnd_q == LAST_RND) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
`ifdef FEISTEL_CTRL_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
`ifdef FEISTEL_CTRL_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = ~in_ready;
    assign bus.out_valid = out_valid;
    // Final swap: the result is presented as {R, L}.
    assign bus.out_block = out_valid ? {r_q, l_q} : 64'd0;
    assign bus.f_left    = in_round ? l_q   : 32'd0;
    assign bus.f_right   = in_round ? r_q   : 32'd0;
    assign bus.f_key     = in_round ? key_q : 48'd0;

endmodule

// File: doc/feistel_round_ctrl.md
FEISTEL_ROUND_CTRL -- requirements
Module: feistel_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 16, is the number of Feistel rounds per block and SHALL be legal from 1 to 32.
REQ-002 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit, is the reset: asynchronous and active-low.
REQ-004 Port in_valid, input, 1 bit, means a block request is offered.
REQ-005 Port in_ready, output, 1 bit, means the controller accepts a request this cycle.
REQ-006 Port in_block, input, 64 bits, is the plaintext: [63:32]=L0, [31:0]=R0.
REQ-007 Port in_seed, input, 48 bits, is the LFSR key seed.
REQ-008 Port f_left, output, 32 bits, drives the external Feistel left_in.
REQ-009 Port f_right, output, 32 bits, drives the external Feistel right_in.
REQ-010 Port f_key, output, 48 bits, drives the external Feistel round_key.
REQ-011 Port f_left_out, input, 32 bits, is the Feistel left_out; it is combinational from f_left, f_right and f_key.
REQ-012 Port f_right_out, input, 32 bits, is the Feistel right_out; it is combinational from f_left, f_right and f_key.
REQ-013 Port out_valid, output, 1 bit, means out_block is valid.
REQ-014 Port out_ready, input, 1 bit, means the consumer accepts out_block.
REQ-015 Port out_block, output, 64 bits, is the result {R_final, L_final}.
REQ-016 Port busy, output, 1 bit, is high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, KEYFWD (present only with the macro), ROUND and DONE.
REQ-018 in_ready SHALL equal (state==IDLE); a transfer occurs on the edge where in_valid and in_ready are both high.
REQ-019 On transfer, the block SHALL latch L=in_block[63:32], R=in_block[31:0], key=in_seed, rnd=0 and enter ROUND.
REQ-020 A zero seed SHALL be replaced by 48'h000000000001, so the LFSR never locks up.
REQ-021 LFSR forward step: fb = k[47]^k[46]^k[20]^k[19]; k_next = {k[46:0], fb}.
REQ-022 In ROUND, f_left=L, f_right=R and f_key=key combinationally; each edge SHALL perform L<=f_left_out, R<=f_right_out, key<=step(key), rnd<=rnd+1.
REQ-023 Round i SHALL use the LFSR state after i steps from the seed, i.e. round 0 uses the seed itself.
REQ-024 After the round with rnd==NUM_ROUNDS-1 is captured, the FSM SHALL enter DONE.
REQ-025 DONE SHALL drive out_valid=1 and out_block={R,L} (final swap), both stable until out_ready.
REQ-026 On out_valid & out_ready the FSM SHALL return to IDLE; in_ready rises the following cycle, with no same-cycle accept.
REQ-027 Latency: with transfer at edge T and out_ready held high, out_valid SHALL be high during cycle T+NUM_ROUNDS; throughput is one block per NUM_ROUNDS+2 cycles.
REQ-028 Outside ROUND, f_left, f_right and f_key SHALL be 0.
REQ-029 in_valid while busy SHALL be ignored; in_block and in_seed are sampled only at transfer.
REQ-030 Backpressure: L, R and key SHALL hold in DONE for any number of cycles.

Reset
REQ-031 While rst_n=0, state=IDLE, L=R=0, key=0, rnd=0, and in_ready=1, out_valid=0, busy=0, out_block=0.
REQ-032 Reset in any state, including mid-ROUND or in DONE, SHALL abandon the block with no output produced.

Configuration
REQ-033 Macro FEISTEL_CTRL_DECRYPT_EN: when defined, the block SHALL add input in_decrypt (1 bit), sampled at transfer.
REQ-034 With the macro and in_decrypt=1, the FSM SHALL go to KEYFWD and advance key NUM_ROUNDS-1 forward steps, then enter ROUND with rnd=0.
REQ-035 In decrypt ROUND, each edge SHALL perform the reverse step: k_prev = {k[0]^k[47]^k[21]^k[20], k[47:1]}.
REQ-036 Decrypt latency SHALL be NUM_ROUNDS-1 cycles longer than encrypt; with in_decrypt=0 behaviour is identical to the no-macro build.
REQ-037 Without the macro, in_decrypt and KEYFWD SHALL NOT exist, and all requests encrypt.

Verification
REQ-038 Seed 48'h000000000001, NUM_ROUNDS=16 -> f_key is 48'h1, 48'h2, 48'h4 on ROUND cycles 0, 1, 2.
REQ-039 Seed 0 -> f_key in round 0 is 48'h000000000001.
REQ-040 in_block 64'h0123456789ABCDEF, out_ready=1 -> out_valid exactly 16 cycles after transfer; out_block matches the bench's software model of 16 rounds plus swap.
REQ-041 out_ready held 0 for 5 cycles in DONE -> out_block and out_valid stable; in_ready stays 0.
REQ-042 rst_n pulsed low at ROUND cycle 7 -> outputs equal reset values immediately; a new block afterwards completes normally.
REQ-043 With FEISTEL_CTRL_DECRYPT_EN, decrypting the REQ-040 ciphertext with the same seed -> out_block 64'h0123456789ABCDEF after 31 cycles.
